// File: rtl/sdram_arbit.sv
// Command-bus arbiter and refresh scheduler for the single-port SDRAM controller.
// Grants the shared command/address/bank pins with fixed priority refresh > write > read.
module sdram_arbit #(
  parameter int REF_CYCLES = 750
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        write_req,
  input  logic        write_end_flag,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank_addr,
  input  logic        read_req,
  input  logic        read_end_flag,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank_addr,
  output logic        ref_req,
  output logic        ref_en,
  output logic        write_en,
  output logic        read_en,
  output logic        ref_overrun,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank
);

  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

  localparam logic [9:0] CNT_LAST = 10'(REF_CYCLES - 1);
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  state_t      state_q;
  logic [9:0]  cnt_q, cnt_d;
  logic        cntEn_q, cntEn_d;
  logic        refReq_q, refReq_d;
  logic        refOverrun_q, refOverrun_d;
  logic        wrap;

  // Refresh timer is released once init_end has been seen and free-runs from then on;
  // a wrap while a refresh is still pending flags an overrun.
  always_comb begin
    wrap         = cntEn_q && (cnt_q == CNT_LAST);
    cntEn_d      = cntEn_q | init_end;
    cnt_d        = cnt_q;
    refReq_d     = refReq_q;
    refOverrun_d = refOverrun_q;
    if (cntEn_q) begin
      cnt_d = wrap ? 10'd0 : cnt_q + 10'd1;
    end
    if (wrap) begin
      refReq_d = 1'b1;
      if (refReq_q) begin
        refOverrun_d = 1'b1;
      end
    end else if (state_q == AREF) begin
      refReq_d = 1'b0;
    end
  end

  // Arbitration FSM plus timer registers; end pulses only matter in their own state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= INIT;
      cnt_q        <= 10'd0;
      cntEn_q      <= 1'b0;
      refReq_q     <= 1'b0;
      refOverrun_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cntEn_q      <= cntEn_d;
      refReq_q     <= refReq_d;
      refOverrun_q <= refOverrun_d;
      case (state_q)
        INIT:    if (init_end) state_q <= ARBIT;
        ARBIT: begin
          if (refReq_q)       state_q <= AREF;
          else if (write_req) state_q <= WRITE;
          else if (read_req)  state_q <= READ;
        end
        AREF:    if (ref_end) state_q <= ARBIT;
        WRITE:   if (write_end_flag) state_q <= ARBIT;
        READ:    if (read_end_flag) state_q <= ARBIT;
        default: state_q <= INIT;
      endcase
    end
  end

  assign ref_req     = refReq_q;
  assign ref_overrun = refOverrun_q;
  assign ref_en      = (state_q == AREF);
  assign write_en    = (state_q == WRITE);
  assign read_en     = (state_q == READ);

  // Pin mux follows the state register directly so a release drives NOP at once.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'd0;
    sdram_bank = 2'b00;
    case (state_q)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'd0;
        sdram_bank = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed scoreboard bench for sdram_arbit: each cycle's expected bus/grant snapshot is
// queued with the stimulus and compared one edge later.
module tb_sdram_arbit;

  localparam int SEL_INIT  = 0;
  localparam int SEL_ARBIT = 1;
  localparam int SEL_AREF  = 2;
  localparam int SEL_WRITE = 3;
  localparam int SEL_READ  = 4;

  localparam logic [3:0]  INIT_CMD  = 4'h1;
  localparam logic [11:0] INIT_ADDR = 12'h111;
  localparam logic [3:0]  REF_CMD   = 4'h2;
  localparam logic [11:0] REF_ADDR  = 12'h222;
  localparam logic [3:0]  WR_CMD    = 4'h4;
  localparam logic [11:0] WR_ADDR   = 12'h444;
  localparam logic [1:0]  WR_BANK   = 2'b01;
  localparam logic [3:0]  RD_CMD    = 4'h5;
  localparam logic [11:0] RD_ADDR   = 12'h555;
  localparam logic [1:0]  RD_BANK   = 2'b10;

  logic        sys_clk = 1'b0;
  logic        sys_rst, init_end, ref_end, write_req, write_end_flag, read_req, read_end_flag;
  logic        ref_req, ref_en, write_en, read_en, ref_overrun;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  typedef struct {
    string       tag;
    logic [22:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int       checks   = 0;
  int       failures = 0;
  int       cyc      = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit #(.REF_CYCLES(750)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .init_end       (init_end),
    .init_cmd       (INIT_CMD),
    .init_addr      (INIT_ADDR),
    .ref_end        (ref_end),
    .ref_cmd        (REF_CMD),
    .ref_addr       (REF_ADDR),
    .write_req      (write_req),
    .write_end_flag (write_end_flag),
    .wr_cmd         (WR_CMD),
    .wr_addr        (WR_ADDR),
    .wr_bank_addr   (WR_BANK),
    .read_req       (read_req),
    .read_end_flag  (read_end_flag),
    .rd_cmd         (RD_CMD),
    .rd_addr        (RD_ADDR),
    .rd_bank_addr   (RD_BANK),
    .ref_req        (ref_req),
    .ref_en         (ref_en),
    .write_en       (write_en),
    .read_en        (read_en),
    .ref_overrun    (ref_overrun),
    .sdram_cmd      (sdram_cmd),
    .sdram_addr     (sdram_addr),
    .sdram_bank     (sdram_bank)
  );

  // Snapshot layout: {ref_req, ref_en, write_en, read_en, ref_overrun, cmd, addr, bank}
  function automatic logic [22:0] expBus(input int sel, input logic rq, input logic ov);
    logic [22:0] v;
    case (sel)
      SEL_INIT:  v = {rq, 1'b0, 1'b0, 1'b0, ov, INIT_CMD, INIT_ADDR, 2'b00};
      SEL_AREF:  v = {rq, 1'b1, 1'b0, 1'b0, ov, REF_CMD, REF_ADDR, 2'b00};
      SEL_WRITE: v = {rq, 1'b0, 1'b1, 1'b0, ov, WR_CMD, WR_ADDR, WR_BANK};
      SEL_READ:  v = {rq, 1'b0, 1'b0, 1'b1, ov, RD_CMD, RD_ADDR, RD_BANK};
      default:   v = {rq, 1'b0, 1'b0, 1'b0, ov, 4'b0111, 12'h000, 2'b00};
    endcase
    return v;
  endfunction

  // Queue the expectation for the coming edge, then advance one clock.
  task automatic applyStimulus(input string tag, input int sel, input logic rq, input logic ov);
    sbEntry_t e;
    e.tag = tag;
    e.exp = expBus(sel, rq, ov);
    sbQ.push_back(e);
    @(posedge sys_clk);
    cyc++;
    #1;
  endtask

  // Pop the oldest expectation and compare against the live DUT outputs.
  task automatic checkOutput();
    sbEntry_t    e;
    logic [22:0] obs;
    if (sbQ.size() == 0) begin
      failures++;
      $error("[TB] FAIL sbEmpty observed=0 expected=1");
      return;
    end
    e   = sbQ.pop_front();
    obs = {ref_req, ref_en, write_en, read_en, ref_overrun, sdram_cmd, sdram_addr, sdram_bank};
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", e.tag, cyc, obs, e.exp);
    end
  endtask

  task automatic step(input string tag, input int sel, input logic rq, input logic ov);
    applyStimulus(tag, sel, rq, ov);
    checkOutput();
  endtask

  initial begin
    sys_rst = 1'b1; init_end = 1'b0; ref_end = 1'b0;
    write_req = 1'b0; write_end_flag = 1'b0; read_req = 1'b0; read_end_flag = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    step("reset", SEL_INIT, 1'b0, 1'b0);
    sys_rst = 1'b0;
    cyc = 0;

    while (cyc < 9) step("initHold", SEL_INIT, 1'b0, 1'b0);
    init_end = 1'b1;
    step("initDone", SEL_ARBIT, 1'b0, 1'b0);                // edge 10, timer released

    write_req = 1'b1; read_req = 1'b1;
    step("wrOverRd", SEL_WRITE, 1'b0, 1'b0);                // 11
    write_req = 1'b0;
    step("wrHold", SEL_WRITE, 1'b0, 1'b0);                  // 12
    write_end_flag = 1'b1;
    step("wrRelease", SEL_ARBIT, 1'b0, 1'b0);               // 13
    write_end_flag = 1'b0;
    step("rdGrant", SEL_READ, 1'b0, 1'b0);                  // 14
    read_req = 1'b0;
    step("rdHold", SEL_READ, 1'b0, 1'b0);                   // 15
    ref_end = 1'b1;
    step("strayRefEnd", SEL_READ, 1'b0, 1'b0);              // 16
    ref_end = 1'b0; read_end_flag = 1'b1;
    step("rdRelease", SEL_ARBIT, 1'b0, 1'b0);               // 17
    read_end_flag = 1'b0;

    while (cyc < 759) step("idleWait", SEL_ARBIT, 1'b0, 1'b0);
    step("firstRefReq", SEL_ARBIT, 1'b1, 1'b0);             // 760
    write_req = 1'b1;
    step("refOverWr", SEL_AREF, 1'b1, 1'b0);                // 761
    step("refReqClr", SEL_AREF, 1'b0, 1'b0);                // 762
    ref_end = 1'b1;
    step("refRelease", SEL_ARBIT, 1'b0, 1'b0);              // 763
    ref_end = 1'b0;
    step("wrAfterRef", SEL_WRITE, 1'b0, 1'b0);              // 764
    write_req = 1'b0;

    while (cyc < 1509) step("wrLong", SEL_WRITE, 1'b0, 1'b0);
    step("wrapInWrite", SEL_WRITE, 1'b1, 1'b0);             // 1510
    step("noRevoke", SEL_WRITE, 1'b1, 1'b0);                // 1511
    write_end_flag = 1'b1;
    step("wrBreak", SEL_ARBIT, 1'b1, 1'b0);                 // 1512
    write_end_flag = 1'b0;
    step("brkRef", SEL_AREF, 1'b1, 1'b0);                   // 1513
    step("brkRefClr", SEL_AREF, 1'b0, 1'b0);                // 1514
    ref_end = 1'b1;
    step("brkRefEnd", SEL_ARBIT, 1'b0, 1'b0);               // 1515
    ref_end = 1'b0; write_req = 1'b1;
    step("ovWrGrant", SEL_WRITE, 1'b0, 1'b0);               // 1516
    write_req = 1'b0;

    while (cyc < 3009) step("ovWait", SEL_WRITE, (cyc + 1 >= 2260), 1'b0);
    step("overrun", SEL_WRITE, 1'b1, 1'b1);                 // 3010
    write_end_flag = 1'b1;
    step("ovWrEnd", SEL_ARBIT, 1'b1, 1'b1);                 // 3011
    write_end_flag = 1'b0;
    step("ovRef", SEL_AREF, 1'b1, 1'b1);                    // 3012
    step("ovRefClr", SEL_AREF, 1'b0, 1'b1);                 // 3013
    ref_end = 1'b1;
    step("ovSticky", SEL_ARBIT, 1'b0, 1'b1);                // 3014
    ref_end = 1'b0; write_req = 1'b1;
    step("preRstWr", SEL_WRITE, 1'b0, 1'b1);                // 3015
    write_req = 1'b0;
    step("preRstHold", SEL_WRITE, 1'b0, 1'b1);              // 3016
    sys_rst = 1'b1;
    step("rstInWrite", SEL_INIT, 1'b0, 1'b0);               // 3017
    sys_rst = 1'b0;
    step("postRst", SEL_ARBIT, 1'b0, 1'b0);                 // 3018, timer released again

    while (cyc < 3767) step("postRstWait", SEL_ARBIT, 1'b0, 1'b0);
    step("postRstRefReq", SEL_ARBIT, 1'b1, 1'b0);           // 3768
    step("postRstRef", SEL_AREF, 1'b1, 1'b0);               // 3769

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
